// File: rtl/wb_queue.sv
// Writeback queue: buffers register-file writebacks in order, retires the head
// whenever the register-file write port is free, and forwards the newest
// pending value for two source addresses so readers never see stale data.
module wb_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_wb_valid,
  input  logic [ADDR_WIDTH-1:0]        i_wb_addr,
  input  logic [DATA_WIDTH-1:0]        i_wb_data,
  output logic                         o_wb_ready,
  input  logic                         i_rf_stall,
  output logic                         o_rf_we,
  output logic [ADDR_WIDTH-1:0]        o_rf_addr,
  output logic [DATA_WIDTH-1:0]        o_rf_data,
  input  logic [ADDR_WIDTH-1:0]        i_rs1_addr,
  input  logic [ADDR_WIDTH-1:0]        i_rs2_addr,
  output logic                         o_rs1_hit,
  output logic                         o_rs2_hit,
  output logic [DATA_WIDTH-1:0]        o_rs1_fwd,
  output logic [DATA_WIDTH-1:0]        o_rs2_fwd,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic                         o_empty,
  output logic                         o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push;
  logic                  pop;

  // Handshake: a writeback transfers on a rising edge where i_wb_valid and
  // o_wb_ready are both high. o_wb_ready depends only on occupancy (never on a
  // same-cycle pop), and a producer seeing ready low holds its offer stable.
  // Offers to x0 complete the handshake but are dropped. The register-file side
  // has no ready: o_rf_we high means the head retires on that edge.
  assign o_empty    = (count == '0);
  assign o_full     = (count == CNT_W'(DEPTH));
  assign o_wb_ready = !o_full;
  assign o_count    = count;

  assign push    = i_wb_valid && o_wb_ready && (i_wb_addr != '0);
  assign o_rf_we = !o_empty && !i_rf_stall;
  assign pop     = o_rf_we;

  assign o_rf_addr = o_empty ? '0 : addr_mem[rd_ptr];
  assign o_rf_data = o_empty ? '0 : data_mem[rd_ptr];

  // Pointer and occupancy state; reset discards every pending entry at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // Entry storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= i_wb_addr;
      data_mem[wr_ptr] <= i_wb_data;
    end
  end

  // Forwarding scan from oldest to newest occupied entry, so the last match
  // (the newest write) wins. The head still counts while it is being popped.
  always_comb begin
    o_rs1_hit = 1'b0;
    o_rs2_hit = 1'b0;
    o_rs1_fwd = '0;
    o_rs2_fwd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count) begin
        if ((i_rs1_addr != '0) && (addr_mem[rd_ptr + PTR_W'(i)] == i_rs1_addr)) begin
          o_rs1_hit = 1'b1;
          o_rs1_fwd = data_mem[rd_ptr + PTR_W'(i)];
        end
        if ((i_rs2_addr != '0) && (addr_mem[rd_ptr + PTR_W'(i)] == i_rs2_addr)) begin
          o_rs2_hit = 1'b1;
          o_rs2_fwd = data_mem[rd_ptr + PTR_W'(i)];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: inputs change 2 units after each rising edge,
// inline checks run 1 unit later, and a falling-edge scoreboard tracks every
// accepted writeback in exp_q and checks each register-file write in order.
module tb_wb_queue;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        rf_stall;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_hit;
  logic        rs2_hit;
  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int total = 0;
  int bad   = 0;
  logic [36:0] exp_q[$];

  wb_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_valid(wb_valid), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_wb_ready(wb_ready),
    .i_rf_stall(rf_stall), .o_rf_we(rf_we), .o_rf_addr(rf_addr), .o_rf_data(rf_data),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
    .o_rs1_hit(rs1_hit), .o_rs2_hit(rs2_hit), .o_rs1_fwd(rs1_fwd), .o_rs2_fwd(rs2_fwd),
    .o_count(count), .o_empty(empty), .o_full(full)
  );

  // Clock: period 20, rising edges at 10, 30, 50, ...
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Driver: present one cycle of inputs shortly after a rising edge.
  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d, input logic s);
    @(posedge clk);
    #2;
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
    rf_stall = s;
  endtask

  // Scoreboard: reference FIFO of accepted writebacks, checked at mid-cycle.
  always @(negedge clk) begin
    int          sz;
    logic        exp_we;
    logic [36:0] head;
    if (!rst) begin
      sz = exp_q.size();
      exp_we = (sz > 0) && !rf_stall;
      total++; if (count !== 3'(sz)) begin bad++; $display("FAIL sb_count got=%0d want=%0d", count, sz); end
      total++; if (wb_ready !== (sz < 4)) begin bad++; $display("FAIL sb_ready got=%0b want=%0b", wb_ready, (sz < 4)); end
      total++; if (rf_we !== exp_we) begin bad++; $display("FAIL sb_rf_we got=%0b want=%0b", rf_we, exp_we); end
      if (exp_we) begin
        head = exp_q.pop_front();
        total++;
        if ({rf_addr, rf_data} !== head) begin
          bad++;
          $display("FAIL sb_retire got=%0d:%0h want=%0d:%0h", rf_addr, rf_data, head[36:32], head[31:0]);
        end
      end
      if (wb_valid && (sz < 4) && (wb_addr != 5'd0)) exp_q.push_back({wb_addr, wb_data});
    end
  end

  task automatic test_reset();
    rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; rf_stall = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    #3;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%0b want=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%0b want=0", full); end
    total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b want=1", wb_ready); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rst_rf_we got=%0b want=0", rf_we); end
    total++; if (rf_addr !== 5'd0 || rf_data !== 32'd0) begin bad++; $display("FAIL rst_rf_bus got=%0d:%0h want=0:0", rf_addr, rf_data); end
    total++; if (rs1_hit !== 1'b0 || rs2_hit !== 1'b0 || rs1_fwd !== 32'd0 || rs2_fwd !== 32'd0) begin
      bad++; $display("FAIL rst_fwd got=%0b%0b %0h %0h want=00 0 0", rs1_hit, rs2_hit, rs1_fwd, rs2_fwd);
    end
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Offer is presented in the same cycle reset releases: first edge must take it.
  task automatic test_single();
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; rf_stall = 1'b0; rs1_addr = 5'd5;
    #1;
    total++; if (rs1_hit !== 1'b0) begin bad++; $display("FAIL single_offer_no_fwd got=%0b want=0", rs1_hit); end
    drive(1'b0, 5'd0, 32'd0, 1'b0); #1;
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL single_we got=%0b want=1", rf_we); end
    total++; if (rf_addr !== 5'd5 || rf_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_bus got=%0d:%0h want=5:deadbeef", rf_addr, rf_data); end
    total++; if (rs1_hit !== 1'b1 || rs1_fwd !== 32'hDEADBEEF) begin bad++; $display("FAIL single_fwd got=%0b:%0h want=1:deadbeef", rs1_hit, rs1_fwd); end
    drive(1'b0, 5'd0, 32'd0, 1'b0); #1;
    total++; if (empty !== 1'b1 || rf_we !== 1'b0) begin bad++; $display("FAIL single_drained got=%0b%0b want=10", empty, rf_we); end
    total++; if (rs1_hit !== 1'b0) begin bad++; $display("FAIL single_fwd_gone got=%0b want=0", rs1_hit); end
    rs1_addr = '0;
  endtask

  task automatic test_fill_stall();
    for (int i = 1; i <= 4; i++) drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1);
    #1;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL fill_count3 got=%0d want=3", count); end
    drive(1'b1, 5'd9, 32'h909, 1'b1); #1;
    total++; if (count !== 3'd4 || full !== 1'b1) begin bad++; $display("FAIL fill_full got=%0d:%0b want=4:1", count, full); end
    total++; if (wb_ready !== 1'b0 || rf_we !== 1'b0) begin bad++; $display("FAIL fill_held got=%0b%0b want=00", wb_ready, rf_we); end
    drive(1'b1, 5'd9, 32'h909, 1'b1); #1;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_hold_count got=%0d want=4", count); end
    drive(1'b1, 5'd9, 32'h909, 1'b0); #1;
    total++; if (rf_we !== 1'b1 || rf_addr !== 5'd1 || rf_data !== 32'h101) begin bad++; $display("FAIL fill_ret1 got=%0b %0d:%0h want=1 1:101", rf_we, rf_addr, rf_data); end
    total++; if (wb_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_nopop got=%0b want=0", wb_ready); end
    drive(1'b1, 5'd9, 32'h909, 1'b0); #1;
    total++; if (count !== 3'd3 || wb_ready !== 1'b1 || rf_addr !== 5'd2) begin bad++; $display("FAIL fill_ret2 got=%0d %0b %0d want=3 1 2", count, wb_ready, rf_addr); end
    drive(1'b0, 5'd0, 32'd0, 1'b0); #1;
    total++; if (count !== 3'd3 || rf_addr !== 5'd3) begin bad++; $display("FAIL fill_ret3 got=%0d %0d want=3 3", count, rf_addr); end
    drive(1'b0, 5'd0, 32'd0, 1'b0); #1;
    total++; if (count !== 3'd2 || rf_addr !== 5'd4) begin bad++; $display("FAIL fill_ret4 got=%0d %0d want=2 4", count, rf_addr); end
    drive(1'b0, 5'd0, 32'd0, 1'b0); #1;
    total++; if (rf_addr !== 5'd9 || rf_data !== 32'h909) begin bad++; $display("FAIL fill_ret_held got=%0d:%0h want=9:909", rf_addr, rf_data); end
    drive(1'b0, 5'd0, 32'd0, 1'b0); #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fill_drained got=%0b want=1", empty); end
  endtask

  task automatic test_forward();
    drive(1'b1, 5'd7, 32'h11, 1'b1);
    drive(1'b1, 5'd7, 32'h22, 1'b1);
    rs1_addr = 5'd7; #1;
    total++; if (rs1_hit !== 1'b1 || rs1_fwd !== 32'h11) begin bad++; $display("FAIL fwd_exclude_offer got=%0b:%0h want=1:11", rs1_hit, rs1_fwd); end
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    rs2_addr = 5'd8; #1;
    total++; if (rs1_hit !== 1'b1 || rs1_fwd !== 32'h22) begin bad++; $display("FAIL fwd_newest got=%0b:%0h want=1:22", rs1_hit, rs1_fwd); end
    total++; if (rs2_hit !== 1'b0 || rs2_fwd !== 32'h0) begin bad++; $display("FAIL fwd_miss got=%0b:%0h want=0:0", rs2_hit, rs2_fwd); end
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    rs2_addr = 5'd7; #1;
    total++; if (rs2_hit !== 1'b1 || rs2_fwd !== 32'h22 || rf_data !== 32'h11) begin bad++; $display("FAIL fwd_port2 got=%0b:%0h head=%0h want=1:22 head=11", rs2_hit, rs2_fwd, rf_data); end
    drive(1'b0, 5'd0, 32'd0, 1'b0); #1;
    total++; if (rf_we !== 1'b1 || rs1_hit !== 1'b1 || rs1_fwd !== 32'h22) begin bad++; $display("FAIL fwd_head_popping got=%0b %0b:%0h want=1 1:22", rf_we, rs1_hit, rs1_fwd); end
    drive(1'b0, 5'd0, 32'd0, 1'b0); #1;
    total++; if (rs1_hit !== 1'b0 || rs1_fwd !== 32'h0) begin bad++; $display("FAIL fwd_cleared got=%0b:%0h want=0:0", rs1_hit, rs1_fwd); end
    rs1_addr = '0; rs2_addr = '0;
  endtask

  task automatic test_x0();
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    rs1_addr = 5'd0; #1;
    total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%0b want=1", wb_ready); end
    total++; if (rs1_hit !== 1'b0) begin bad++; $display("FAIL x0_hit got=%0b want=0", rs1_hit); end
    drive(1'b0, 5'd0, 32'd0, 1'b0); #1;
    total++; if (count !== 3'd0 || rf_we !== 1'b0) begin bad++; $display("FAIL x0_dropped got=%0d:%0b want=0:0", count, rf_we); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'(10 + i), 32'h1111 * 32'(i + 1), 1'b0); #1;
      if (i > 0) begin
        total++;
        if (count !== 3'd1 || rf_we !== 1'b1 || rf_addr !== 5'(9 + i)) begin
          bad++; $display("FAIL b2b_step%0d got=%0d %0b %0d want=1 1 %0d", i, count, rf_we, rf_addr, 9 + i);
        end
      end
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0); #1;
    total++; if (rf_addr !== 5'd19 || rf_data !== 32'hAAAA) begin bad++; $display("FAIL b2b_last got=%0d:%0h want=19:aaaa", rf_addr, rf_data); end
    drive(1'b0, 5'd0, 32'd0, 1'b0); #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_drained got=%0b want=1", empty); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 5'(20 + i), 32'hA0 + 32'(i), 1'b1);
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    rs1_addr = 5'd21; #1;
    total++; if (count !== 3'd3 || rs1_hit !== 1'b1) begin bad++; $display("FAIL arst_pending got=%0d:%0b want=3:1", count, rs1_hit); end
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    total++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL arst_count got=%0d %0b%0b want=0 10", count, empty, full); end
    total++; if (rf_we !== 1'b0 || rf_addr !== 5'd0 || rf_data !== 32'd0) begin bad++; $display("FAIL arst_rf got=%0b %0d:%0h want=0 0:0", rf_we, rf_addr, rf_data); end
    total++; if (rs1_hit !== 1'b0 || rs1_fwd !== 32'd0 || wb_ready !== 1'b1) begin bad++; $display("FAIL arst_fwd got=%0b:%0h rdy=%0b want=0:0 rdy=1", rs1_hit, rs1_fwd, wb_ready); end
    #1;
    rst = 1'b0;
    rf_stall = 1'b0;
    rs1_addr = '0;
    drive(1'b0, 5'd0, 32'd0, 1'b0); #1;
    total++; if (rf_we !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL arst_no_write got=%0b:%0d want=0:0", rf_we, count); end
    drive(1'b1, 5'd3, 32'hABC, 1'b0);
    drive(1'b0, 5'd0, 32'd0, 1'b0); #1;
    total++; if (rf_we !== 1'b1 || rf_addr !== 5'd3 || rf_data !== 32'hABC) begin bad++; $display("FAIL arst_recover got=%0b %0d:%0h want=1 3:abc", rf_we, rf_addr, rf_data); end
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    drive(1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_forward();
    test_x0();
    test_back_to_back();
    test_async_reset();
    #1;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
